// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage register.
// Define PIPE_SKID_EN to build pipe_stage_reg with a registered-ready skid entry.
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;  // addi x0, x0, 0
  localparam int          DATA_W_DEF = 133;
  localparam int          CTRL_W_DEF = 9;
  localparam int          CNT_W_DEF  = 16;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_bundle_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bus of one pipeline stage: upstream beat, downstream beat, flush and bubble count.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [31:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       out_instr;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_instr, bubble_cnt
  );
  modport slave (
    input  in_valid, in_data, in_ctrl, in_instr, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_instr, bubble_cnt
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Spare beat entry behind a stalled main register; ready is registered (skid entry empty).
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o,
  output logic         rdy_o
);
  logic [W-1:0] data_q;
  logic         vld_q, vld_d, rdy_q;

  always_comb begin
    vld_d = vld_q;
    if (flush_i || pop_i) vld_d = 1'b0;
    else if (push_i)      vld_d = 1'b1;
  end

  // Ready is computed from the next occupancy so it has no path from out_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      rdy_q <= !vld_d;
      if (push_i && !flush_i) data_q <= d_i;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;
  assign rdy_o = rdy_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush-to-bubble and saturating bubble counter.
// PIPE_SKID_EN adds a skid entry and makes in_ready a flop output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  pipe_stage_reg_if.slave  bus
);
  localparam int BW = DATA_W + CTRL_W + 32;

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       instr_q;
  logic              vld_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall, in_fire, in_ready;
  logic              load;
  logic [BW-1:0]     load_beat;

  assign stall   = vld_q && !bus.out_ready;
  assign in_fire = bus.in_valid && in_ready;
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef PIPE_SKID_EN
  logic [BW-1:0] skid_beat;
  logic          skid_vld, skid_rdy;

  pipe_skid_buf #(.W(BW)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .flush_i (bus.flush),
    .push_i  (in_fire && stall),
    .pop_i   (skid_vld && !stall),
    .d_i     ({bus.in_data, bus.in_ctrl, bus.in_instr}),
    .q_o     (skid_beat),
    .vld_o   (skid_vld),
    .rdy_o   (skid_rdy)
  );

  // The skid entry is older than any incoming beat, so it drains first.
  assign in_ready  = skid_rdy;
  assign load      = !stall && (skid_vld || in_fire);
  assign load_beat = skid_vld ? skid_beat : {bus.in_data, bus.in_ctrl, bus.in_instr};
`else
  assign in_ready  = bus.flush || !vld_q || bus.out_ready;
  assign load      = in_fire;
  assign load_beat = {bus.in_data, bus.in_ctrl, bus.in_instr};
`endif

  // Flush keeps the data bundle so downstream hazard logic still sees valid indices.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        data_q  <= bus.in_data;
        ctrl_q  <= '0;
        instr_q <= NOP_INSTR;
        cnt_q   <= cnt_d;
      end
    end else if (load) begin
      vld_q                     <= 1'b1;
      {data_q, ctrl_q, instr_q} <= load_beat;
    end else if (!stall) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = vld_q;
  assign bus.out_data   = data_q;
  assign bus.out_ctrl   = ctrl_q;
  assign bus.out_instr  = instr_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; counter width 2 to reach saturation quickly.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int CW = CTRL_W_DEF;
  localparam int NW = 2;

  logic clock, reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [DW-1:0] d1, d2, d4, d7;
  ctrl_bundle_t  cfull;

  initial begin
    d1 = DW'(64'hDEAD_BEEF_0000_0001);
    d2 = DW'(64'h0123_4567_89AB_CDEF);
    d4 = DW'(64'hCAFE_F00D_1234_5678);
    d7 = DW'(64'h0000_0777_0000_0777);
    cfull = '1;

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.in_instr = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data",  bus.out_data, '0);
    chk("rst_ctrl",  bus.out_ctrl, '0);
    chk("rst_instr", bus.out_instr, NOP_INSTR);
    chk("rst_cnt",   bus.bubble_cnt, '0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", bus.in_ready, 1'b1);

    // Back-to-back streaming
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.in_instr = 32'h00A00093; bus.in_data = d1; bus.in_ctrl = 9'h021;
    step();
    chk("s1_valid", bus.out_valid, 1'b1);
    chk("s1_instr", bus.out_instr, 32'h00A00093);
    chk("s1_data",  bus.out_data, d1);
    chk("s1_ctrl",  bus.out_ctrl, 9'h021);
    bus.in_instr = 32'h00100113; bus.in_data = d2; bus.in_ctrl = 9'h042;
    step();
    chk("s2_valid", bus.out_valid, 1'b1);
    chk("s2_instr", bus.out_instr, 32'h00100113);
    chk("s2_data",  bus.out_data, d2);
    chk("s2_ready", bus.in_ready, 1'b1);

    // Stall with a beat held; a third beat is offered throughout
    bus.out_ready = 1'b0;
    bus.in_instr = 32'h002081B3; bus.in_data = d4; bus.in_ctrl = 9'h003;
    #1;
`ifdef PIPE_SKID_EN
    chk("st_ready0", bus.in_ready, 1'b1);
`else
    chk("st_ready0", bus.in_ready, 1'b0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_valid", bus.out_valid, 1'b1);
      chk("st_instr", bus.out_instr, 32'h00100113);
      chk("st_data",  bus.out_data, d2);
      chk("st_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("rl_instr", bus.out_instr, 32'h002081B3);
    chk("rl_data",  bus.out_data, d4);
    chk("rl_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk("rl_drain", bus.out_valid, 1'b0);

    // Flush with an incoming beat becomes a bubble carrying the data
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    bus.in_ctrl = cfull; bus.in_data = d4; bus.in_instr = 32'h00C58633;
    step();
    chk("fl_ctrl",  bus.out_ctrl, '0);
    chk("fl_instr", bus.out_instr, NOP_INSTR);
    chk("fl_data",  bus.out_data, d4);
    chk("fl_valid", bus.out_valid, 1'b1);
    chk("fl_cnt",   bus.bubble_cnt, 2'd1);

    // Flush while stalled (skid filled in that build), no incoming beat
    bus.flush = 1'b0; bus.in_ctrl = 9'h005; bus.in_instr = 32'h00500293; bus.in_data = d1;
    step();
    chk("f2_instr", bus.out_instr, 32'h00500293);
    bus.out_ready = 1'b0; bus.in_instr = 32'h00600313; bus.in_data = d2;
    step();
    chk("f2_hold",  bus.out_instr, 32'h00500293);
    chk("f2_rdy0",  bus.in_ready, 1'b0);
    bus.flush = 1'b1; bus.in_valid = 1'b0;
    #1;
`ifndef PIPE_SKID_EN
    chk("f2_force", bus.in_ready, 1'b1);
`endif
    step();
    chk("f2_valid", bus.out_valid, 1'b0);
    chk("f2_ready", bus.in_ready, 1'b1);
    chk("f2_cnt",   bus.bubble_cnt, 2'd1);
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("f2_empty", bus.out_valid, 1'b0);

    // Counter saturates at all-ones
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_ctrl = cfull;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_cnt", bus.bubble_cnt, (i == 0) ? 2'd2 : 2'd3);
    end
    chk("sat_ctrl", bus.out_ctrl, '0);
    bus.flush = 1'b0;

    // Reset while a beat is held under back-pressure
    bus.in_instr = 32'h00700393; bus.in_data = d7; bus.in_ctrl = 9'h011;
    step();
    chk("mr_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_rvalid", bus.out_valid, 1'b0);
    chk("mr_rdata",  bus.out_data, '0);
    chk("mr_rctrl",  bus.out_ctrl, '0);
    chk("mr_rinstr", bus.out_instr, NOP_INSTR);
    chk("mr_rcnt",   bus.bubble_cnt, '0);
    step();
    reset_n = 1'b1;
    #1;
    chk("mr_ready", bus.in_ready, 1'b1);
    step();
    chk("mr_idle", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
